// File: rtl/dcache_pkg.sv
// Shared constants and state encoding for the direct-mapped write-back data cache controller.
package dcache_pkg;
  localparam int INDEX_W_DEF = 5;
  localparam int TAG_W_DEF   = 22;
  localparam int LINE_W_DEF  = 256;
  localparam int WORD_W      = 32;
  localparam int WOFF_W      = 3;

  localparam int TAG_VALID_BIT = 23;
  localparam int TAG_DIRTY_BIT = 22;

  localparam int ADDR_TAG_MSB  = 31;
  localparam int ADDR_TAG_LSB  = 10;
  localparam int ADDR_IDX_MSB  = 9;
  localparam int ADDR_IDX_LSB  = 5;
  localparam int ADDR_WORD_MSB = 4;
  localparam int ADDR_WORD_LSB = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_MISS,
    ST_WRITEBACK,
    ST_ALLOCATE,
    ST_REFILL_DONE
  } state_e;
endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side request port and off-chip memory port of the data cache controller.
interface dcache_ctrl_if;
  logic         p1_req_i;
  logic         p1_write_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_word_merge.sv
// Selects one word out of a cache line and builds the same line with that word replaced.
module dcache_word_merge #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int SEL_W  = 3
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LINE_W-1:0] line_o
);
  always_comb begin
    word_o = line_i[sel_i*WORD_W +: WORD_W];
    line_o = line_i;
    line_o[sel_i*WORD_W +: WORD_W] = word_i;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller: tag compare,
// store merge, dirty write-back and refill sequencing, plus a post-reset tag sweep.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int LINE_W  = LINE_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_ctrl_if.slave        bus,
  output logic                tag_enable_o,
  output logic                tag_write_o,
  output logic [INDEX_W-1:0]  tag_addr_o,
  output logic [TAG_W+1:0]    tag_data_o,
  input  logic [TAG_W+1:0]    tag_data_i,
  output logic                data_enable_o,
  output logic                data_write_o,
  output logic [INDEX_W-1:0]  data_addr_o,
  output logic [LINE_W-1:0]   data_wdata_o,
  input  logic [LINE_W-1:0]   data_rdata_i
);
  localparam logic [INDEX_W-1:0] LAST_IDX = '1;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [WOFF_W-1:0]  wsel;
  logic               hit;
  logic               victim_dirty;
  logic [WORD_W-1:0]  rd_word;
  logic [LINE_W-1:0]  merged_line;
  logic               unused_addr_bits;

  assign idx     = bus.p1_addr_i[ADDR_IDX_MSB:ADDR_IDX_LSB];
  assign req_tag = bus.p1_addr_i[ADDR_TAG_MSB:ADDR_TAG_LSB];
  assign wsel    = bus.p1_addr_i[ADDR_WORD_MSB:ADDR_WORD_LSB];
  assign unused_addr_bits = &{1'b0, bus.p1_addr_i[1:0]};

  assign hit          = tag_data_i[TAG_VALID_BIT] && (tag_data_i[TAG_W-1:0] == req_tag);
  assign victim_dirty = tag_data_i[TAG_VALID_BIT] && tag_data_i[TAG_DIRTY_BIT];

  dcache_word_merge #(
    .LINE_W (LINE_W),
    .WORD_W (WORD_W),
    .SEL_W  (WOFF_W)
  ) u_merge (
    .line_i (data_rdata_i),
    .sel_i  (wsel),
    .word_i (bus.p1_data_i),
    .word_o (rd_word),
    .line_o (merged_line)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    tag_enable_o     = 1'b0;
    tag_write_o      = 1'b0;
    tag_addr_o       = idx;
    tag_data_o       = '0;
    data_enable_o    = 1'b0;
    data_write_o     = 1'b0;
    data_addr_o      = idx;
    data_wdata_o     = merged_line;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    bus.p1_stall_o   = 1'b1;
    bus.p1_data_o    = '0;

    unique case (state_q)
      ST_INIT: begin
        // The sweep write is gated by reset so the RAMs stay quiet while held in reset.
        tag_enable_o = rst_i;
        tag_write_o  = rst_i;
        tag_addr_o   = cnt_q;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!bus.p1_req_i) begin
          bus.p1_stall_o = 1'b0;
        end else begin
          tag_enable_o  = 1'b1;
          data_enable_o = 1'b1;
          if (hit) begin
            bus.p1_stall_o = 1'b0;
            if (bus.p1_write_i) begin
              data_write_o = 1'b1;
              data_wdata_o = merged_line;
              tag_write_o  = 1'b1;
              tag_data_o   = {1'b1, 1'b1, req_tag};
            end else begin
              bus.p1_data_o = rd_word;
            end
          end else begin
            state_d = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        tag_enable_o  = 1'b1;
        data_enable_o = 1'b1;
        state_d       = victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
      end
      ST_WRITEBACK: begin
        // The victim's tag and line are still in the RAMs until the refill lands.
        tag_enable_o     = 1'b1;
        data_enable_o    = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {tag_data_i[TAG_W-1:0], idx, 5'b0};
        bus.mem_data_o   = data_rdata_i;
        if (bus.mem_ack_i) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {req_tag, idx, 5'b0};
        if (bus.mem_ack_i) begin
          tag_enable_o  = 1'b1;
          tag_write_o   = 1'b1;
          tag_data_o    = {1'b1, 1'b0, req_tag};
          data_enable_o = 1'b1;
          data_write_o  = 1'b1;
          data_wdata_o  = bus.mem_data_i;
          state_d       = ST_REFILL_DONE;
        end
      end
      ST_REFILL_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller between the CPU memory stage and the off-chip memory port.
- Drives the 32-entry x 24-bit tag RAM (combinational read, posedge write) and a matching 32 x 256-bit data RAM.
- Compares tags, merges CPU stores into lines, and sequences dirty write-back and line refill over a request/ack memory handshake.
- After reset it sweeps the tag RAM to invalidate every line.

Parameters:
- INDEX_W, 5, index bits (32 lines)
- TAG_W, 22, address tag bits; tag-RAM entry = {valid, dirty, tag} = TAG_W+2 = 24 bits
- LINE_W, 256, line width (32-byte line, 8 words)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- p1_req_i  in  1  CPU access request
- p1_write_i  in  1  1 = store, 0 = load
- p1_addr_i  in  32  byte address: tag [31:10], index [9:5], word [4:2]
- p1_data_i  in  32  store data
- p1_data_o  out  32  load data
- p1_stall_o  out  1  CPU must hold the request
- tag_enable_o / tag_write_o  out  1 / 1  tag RAM controls
- tag_addr_o  out  5  tag RAM index
- tag_data_o  out  24  tag RAM write data
- tag_data_i  in  24  tag RAM read data
- data_enable_o / data_write_o  out  1 / 1  data RAM controls
- data_addr_o  out  5  data RAM index
- data_wdata_o  out  256  data RAM write data
- data_rdata_i  in  256  data RAM read data
- mem_enable_o / mem_write_o  out  1 / 1  memory request, 1 = write
- mem_addr_o  out  32  line-aligned address, bits [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- States: INIT, IDLE, MISS, WRITEBACK, ALLOCATE, REFILL_DONE.
- Reset (async, rst_i=0):
  - State goes to INIT and the 5-bit init counter clears.
  - Outputs take their reset values immediately: mem_enable_o=0, mem_write_o=0, p1_stall_o=1, p1_data_o=0, all RAM enables/writes 0.
- INIT:
  - Each cycle writes tag_data_o=0 at tag_addr_o=counter and increments the counter.
  - Leaves for IDLE after index 31 is written; the sweep takes 32 cycles.
  - p1_stall_o=1 throughout. Data RAM is untouched.
- Hit definition: hit = tag_data_i[23] && tag_data_i[21:0] == p1_addr_i[31:10]. All comparison is combinational on the current index.
- IDLE, no request: p1_stall_o=0 and no RAM writes.
- IDLE, read hit:
  - p1_data_o = data_rdata_i word selected by addr[4:2], same cycle.
  - p1_stall_o=0.
- IDLE, write hit (same cycle):
  - Data RAM gets the line with word addr[4:2] replaced by p1_data_i.
  - Tag RAM gets {1,1,tag}.
  - p1_stall_o=0.
- IDLE, miss: p1_stall_o=1 and the next state is MISS.
- MISS: if the victim entry has valid=1 and dirty=1, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=data_rdata_i.
  - Outputs are held unchanged until mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}.
  - On mem_ack_i: data RAM <= mem_data_i and tag RAM <= {1,0,req tag} in the same cycle, then go to REFILL_DONE.
- REFILL_DONE:
  - mem_enable_o=0, then go to IDLE.
  - The access re-evaluates there as a hit; a store sets dirty at that point.
- Stall timing: p1_stall_o=1 in every state except IDLE.
  - Clean-miss latency = 3 cycles + ack wait.
  - Dirty-miss latency = 4 cycles + two ack waits.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- The CPU holds its address and data stable while stalled. The controller latches nothing from the CPU.
- Reset mid-transaction abandons it, drops mem_enable_o asynchronously and re-runs INIT.

Decomposition:
- Shared package dcache_pkg holds:
  - field constants TAG_VALID_BIT=23, TAG_DIRTY_BIT=22;
  - address field ranges;
  - the state enum.
- One sub-module, dcache_word_merge: combinational select/insert of a 32-bit word into a 256-bit line by word offset. Used for both the read mux and the store merge.

Test Plan:
- Reset, then 32 cycles: tag writes at indices 0..31 with data 0. p1_stall_o=1 until cycle 32, then 0.
- Read 0x0000_0404 cold:
  - MISS then ALLOCATE with mem_addr_o=0x0000_0400 and no write-back.
  - ack with line word1=0xDEADBEEF → tag entry 0x80_0001, p1_data_o=0xDEADBEEF.
- Store 0x12345678 to 0x0000_0408 after the above:
  - Zero-stall hit, tag entry becomes 0xC0_0001, line word2=0x12345678.
- Read 0x0000_0C08 (same index, new tag):
  - WRITEBACK to 0x0000_0400 carrying the merged line, then ALLOCATE to 0x0000_0C00.
  - Final tag entry 0x80_0003.
- Hold mem_ack_i low 10 cycles in ALLOCATE: mem_enable_o, mem_addr_o and p1_stall_o stay constant, with no RAM writes.
- Assert rst_i=0 mid-WRITEBACK: mem_enable_o falls without a clock edge. After release, INIT sweep repeats.
